// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes (also used by the
// ALU control decoder) and the sequencing FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_EQ   = 4'd5;
    localparam logic [3:0] ALU_NE   = 4'd6;
    localparam logic [3:0] ALU_LT   = 4'd7;
    localparam logic [3:0] ALU_GE   = 4'd8;
    localparam logic [3:0] ALU_LTU  = 4'd9;
    localparam logic [3:0] ALU_GEU  = 4'd10;
    localparam logic [3:0] ALU_SLL  = 4'd11;
    localparam logic [3:0] ALU_SRL  = 4'd12;
    localparam logic [3:0] ALU_SRA  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: loads operand and amount on start,
// then shifts and counts down; last flags the final step.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [XLEN-1:0]    operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               last,
    output logic [XLEN-1:0]    shifted
);

    logic [XLEN-1:0]    sreg_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [3:0]         op_r;

    // One-step shift of the current register with op-dependent fill bit
    always_comb begin
        shifted = sreg_r;
        case (op_r)
            ALU_SLL: shifted = {sreg_r[XLEN-2:0], 1'b0};
            ALU_SRL: shifted = {1'b0, sreg_r[XLEN-1:1]};
            ALU_SRA: shifted = {sreg_r[XLEN-1], sreg_r[XLEN-1:1]};
            default: shifted = sreg_r;
        endcase
    end

    assign last = (cnt_r == {{(SHAMT_W-1){1'b0}}, 1'b1});

    // Shift register and down-counter; a zero count means idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_r <= {XLEN{1'b0}};
            cnt_r  <= {SHAMT_W{1'b0}};
            op_r   <= ALU_SLL;
        end else if (start) begin
            sreg_r <= operand;
            cnt_r  <= shamt;
            op_r   <= op;
        end else if (cnt_r != {SHAMT_W{1'b0}}) begin
            sreg_r <= shifted;
            cnt_r  <= cnt_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
        end else begin
            sreg_r <= sreg_r;
            cnt_r  <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready on both sides: single-cycle logic,
// arithmetic and compares, iterative shifts.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            cmp_true
);

    state_t             state_r, state_n, load_state_s;
    logic [XLEN-1:0]    result_r, result_n, load_result_s, alu_res_s, shift_data_s;
    logic               cmp_r, cmp_n, load_cmp_s, alu_cmp_s;
    logic               accept_s, is_shift_s, start_s, load_start_s, shift_last_s;
    logic [SHAMT_W-1:0] shamt_s;

    assign in_ready   = rst_n & ((state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready));
    assign accept_s   = in_valid & in_ready;
    assign shamt_s    = src_b[SHAMT_W-1:0];
    assign is_shift_s = (alu_ctrl == ALU_SLL) | (alu_ctrl == ALU_SRL) | (alu_ctrl == ALU_SRA);
    assign out_valid  = (state_r == ST_DONE);
    assign result     = result_r;
    assign cmp_true   = cmp_r;

    // Single-cycle datapath; compares return the condition zero-extended
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        alu_cmp_s = 1'b0;
        case (alu_ctrl)
            ALU_AND: alu_res_s = src_a & src_b;
            ALU_OR:  alu_res_s = src_a | src_b;
            ALU_ADD: alu_res_s = src_a + src_b;
            ALU_SUB: alu_res_s = src_a - src_b;
            ALU_XOR: alu_res_s = src_a ^ src_b;
            ALU_EQ: begin
                alu_cmp_s = (src_a == src_b);
                alu_res_s = {{(XLEN-1){1'b0}}, alu_cmp_s};
            end
            ALU_NE: begin
                alu_cmp_s = (src_a != src_b);
                alu_res_s = {{(XLEN-1){1'b0}}, alu_cmp_s};
            end
            ALU_LT: begin
                alu_cmp_s = ($signed(src_a) < $signed(src_b));
                alu_res_s = {{(XLEN-1){1'b0}}, alu_cmp_s};
            end
            ALU_GE: begin
                alu_cmp_s = ($signed(src_a) >= $signed(src_b));
                alu_res_s = {{(XLEN-1){1'b0}}, alu_cmp_s};
            end
            ALU_LTU: begin
                alu_cmp_s = (src_a < src_b);
                alu_res_s = {{(XLEN-1){1'b0}}, alu_cmp_s};
            end
            ALU_GEU: begin
                alu_cmp_s = (src_a >= src_b);
                alu_res_s = {{(XLEN-1){1'b0}}, alu_cmp_s};
            end
            default: begin
                alu_res_s = {XLEN{1'b0}};
                alu_cmp_s = 1'b0;
            end
        endcase
    end

    // Outcome of accepting the offered op; a zero shift completes immediately
    always_comb begin
        load_start_s  = 1'b0;
        load_state_s  = ST_DONE;
        load_result_s = alu_res_s;
        load_cmp_s    = alu_cmp_s;
        if (is_shift_s) begin
            load_cmp_s = 1'b0;
            if (shamt_s != {SHAMT_W{1'b0}}) begin
                load_start_s  = 1'b1;
                load_state_s  = ST_SHIFT;
                load_result_s = result_r;
            end else begin
                load_result_s = src_a;
            end
        end else begin
            load_state_s = ST_DONE;
        end
    end

    // Next-state logic; results stay frozen in DONE until the consumer takes them
    always_comb begin
        state_n  = state_r;
        result_n = result_r;
        cmp_n    = cmp_r;
        start_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n  = load_state_s;
                    result_n = load_result_s;
                    cmp_n    = load_cmp_s;
                    start_s  = load_start_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_last_s) begin
                    state_n  = ST_DONE;
                    result_n = shift_data_s;
                    cmp_n    = 1'b0;
                end else begin
                    state_n = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (accept_s) begin
                        state_n  = load_state_s;
                        result_n = load_result_s;
                        cmp_n    = load_cmp_s;
                        start_s  = load_start_s;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            result_r <= {XLEN{1'b0}};
            cmp_r    <= 1'b0;
        end else begin
            state_r  <= state_n;
            result_r <= result_n;
            cmp_r    <= cmp_n;
        end
    end

    alu_shift_iter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s),
        .op      (alu_ctrl),
        .operand (src_a),
        .shamt   (shamt_s),
        .last    (shift_last_s),
        .shifted (shift_data_s)
    );

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized and directed bench for alu_multicycle against an
// arithmetic reference model of the op set, latency and handshake.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, cmp_true;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a, src_b, result;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  q_op[$];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always #5 clk = ~clk;

    alu_multicycle #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cmp_true  (cmp_true)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_shift(input logic [3:0] op);
        return (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
    endfunction

    // Reference model: {cmp_true, result}
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        logic        c;
        sh = b % 32;
        r  = 32'd0;
        c  = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a - b;
            4'd4:  r = a ^ b;
            4'd5:  c = (a == b);
            4'd6:  c = (a != b);
            4'd7:  c = ($signed(a) < $signed(b));
            4'd8:  c = !($signed(a) < $signed(b));
            4'd9:  c = (a < b);
            4'd10: c = !(a < b);
            4'd11: r = a << sh;
            4'd12: r = a >> sh;
            4'd13: r = $signed(a) >>> sh;
            default: r = 32'd0;
        endcase
        if (op >= 4'd5 && op <= 4'd10) r = {31'd0, c};
        return {c, r};
    endfunction

    // One transaction from idle: latency, result, hold under stall, then release
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [32:0] e;
        int exp_lat, lat;
        e       = ref_alu(op, a, b);
        exp_lat = is_shift(op) ? (b % 32) + 1 : 1;
        check("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        alu_ctrl  = op;
        src_a     = a;
        src_b     = b;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b1;
        alu_ctrl = 4'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
        lat = 1;
        while (!out_valid && lat < 64) begin
            check("busy_in_ready", in_ready, 0);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, exp_lat);
        check("out_valid", out_valid, 1);
        check("result", result, e[31:0]);
        check("cmp_true", cmp_true, e[32]);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", out_valid, 1);
            check("stall_result", result, e[31:0]);
            check("stall_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("after_valid", out_valid, 0);
        check("after_in_ready", in_ready, 1);
    endtask

    // Back-to-back stream of single-cycle ops with out_ready held high
    task automatic run_stream();
        logic [32:0] e;
        int n;
        n = q_op.size();
        out_ready = 1'b1;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                e = ref_alu(q_op[k-1], q_a[k-1], q_b[k-1]);
                check("b2b_valid", out_valid, 1);
                check("b2b_result", result, e[31:0]);
                check("b2b_cmp", cmp_true, e[32]);
            end
            check("b2b_in_ready", in_ready, 1);
            if (k < n) begin
                in_valid = 1'b1;
                alu_ctrl = q_op[k];
                src_a    = q_a[k];
                src_b    = q_b[k];
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("b2b_drain", out_valid, 0);
        q_op.delete();
        q_a.delete();
        q_b.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 4'd0;
        src_a     = 32'd0;
        src_b     = 32'd0;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_cmp", cmp_true, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        do_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        q_op = '{4'd3, 4'd7, 4'd9};
        q_a  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        q_b  = '{32'd7, 32'd1, 32'd1};
        run_stream();
        do_op(4'd13, 32'h8000_0000, 32'h0000_0024, 0);
        do_op(4'd13, 32'h8000_0000, 32'h0000_0020, 0);
        do_op(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 3);
        do_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        do_op(4'd14, 32'hFFFF_FFFF, 32'h0000_0003, 1);
        do_op(4'd11, 32'h0000_0001, 32'h0000_001F, 0);
        do_op(4'd12, 32'h8000_0000, 32'hFFFF_FFE1, 0);

        // Reset in the middle of a long shift
        in_valid  = 1'b1;
        alu_ctrl  = 4'd11;
        src_a     = 32'd1;
        src_b     = 32'd20;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("mid_shift_valid", out_valid, 0);
        rst_n = 1'b0;
        #1;
        check("rst_hold_in_ready", in_ready, 0);
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_cmp", cmp_true, 0);
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", in_ready, 1);
        repeat (20) tick();
        check("no_stale_valid", out_valid, 0);
        check("idle_in_ready2", in_ready, 1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_op(4'($urandom_range(0, 15)), a, b, $urandom_range(0, 2));
        end

        for (int i = 0; i < 12; i++) begin
            int unsigned o;
            o = $urandom_range(0, 12);
            q_op.push_back((o > 10) ? 4'(o + 3) : 4'(o));
            q_a.push_back($urandom);
            q_b.push_back(($urandom_range(0, 2) == 0) ? q_a[i] : $urandom);
        end
        run_stream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
